mc_ctrl: RTL

Multi-cycle control unit for the MIPS core. It decodes the latched instruction and produces the `ALU_sel` encoding the ALU consumes. It sequences FETCH/DECODE/EXEC/MEM/WB with a ready handshake to memory, and uses the ALU `zero` (branch-taken) flag to resolve `beq`/`bne`. It sits between the instruction register/memory port and the datapath muxes, register file and ALU.

---
 rtl/mips_defs_pkg.sv | 104 ++++++++++
 rtl/mc_decode.sv | 142 ++++++++++++++
 rtl/mc_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs (package)
// Description : Shared definitions for the multi-cycle MIPS control unit:
//               FSM state encoding, instruction classes, ALU_sel codes,
//               opcode/funct constants and datapath mux select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    // FSM states; the numeric values are visible on the debug 'state' port.
    typedef enum logic [2:0] {
        c_st_fetch  = 3'd0,
        c_st_decode = 3'd1,
        c_st_exec   = 3'd2,
        c_st_mem    = 3'd3,
        c_st_wb     = 3'd4
    } state_t;

    // Instruction classes that steer the sequencing.
    typedef enum logic [3:0] {
        c_cls_ralu   = 4'd0,
        c_cls_ialu   = 4'd1,
        c_cls_load   = 4'd2,
        c_cls_store  = 4'd3,
        c_cls_branch = 4'd4,
        c_cls_j      = 4'd5,
        c_cls_jal    = 4'd6,
        c_cls_jr     = 4'd7,
        c_cls_jalr   = 4'd8,
        c_cls_none   = 4'd9
    } iclass_t;

    // ALU operation codes (encoding shared with the ALU).
    localparam logic [5:0] c_alu_add  = 6'd0;
    localparam logic [5:0] c_alu_sub  = 6'd1;
    localparam logic [5:0] c_alu_ori  = 6'd2;
    localparam logic [5:0] c_alu_sw   = 6'd3;
    localparam logic [5:0] c_alu_sh   = 6'd4;
    localparam logic [5:0] c_alu_sb   = 6'd5;
    localparam logic [5:0] c_alu_lw   = 6'd6;
    localparam logic [5:0] c_alu_lh   = 6'd7;
    localparam logic [5:0] c_alu_lb   = 6'd8;
    localparam logic [5:0] c_alu_and  = 6'd9;
    localparam logic [5:0] c_alu_or   = 6'd10;
    localparam logic [5:0] c_alu_j    = 6'd11;
    localparam logic [5:0] c_alu_jal  = 6'd12;
    localparam logic [5:0] c_alu_jalr = 6'd13;
    localparam logic [5:0] c_alu_jr   = 6'd14;
    localparam logic [5:0] c_alu_beq  = 6'd15;
    localparam logic [5:0] c_alu_bne  = 6'd16;
    localparam logic [5:0] c_alu_addi = 6'd17;
    localparam logic [5:0] c_alu_lui  = 6'd18;
    localparam logic [5:0] c_alu_sll  = 6'd19;

    // Primary opcodes.
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lb    = 6'h20;
    localparam logic [5:0] c_op_lh    = 6'h21;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sb    = 6'h28;
    localparam logic [5:0] c_op_sh    = 6'h29;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    // R-type funct codes.
    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_jalr = 6'h09;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;

    // Datapath mux selects.
    localparam logic [1:0] c_pcsrc_pc4    = 2'd0;
    localparam logic [1:0] c_pcsrc_branch = 2'd1;
    localparam logic [1:0] c_pcsrc_jump   = 2'd2;
    localparam logic [1:0] c_pcsrc_rs     = 2'd3;

    localparam logic [1:0] c_srcb_rt   = 2'd0;
    localparam logic [1:0] c_srcb_sext = 2'd1;
    localparam logic [1:0] c_srcb_zext = 2'd2;

    localparam logic [1:0] c_dst_rt = 2'd0;
    localparam logic [1:0] c_dst_rd = 2'd1;
    localparam logic [1:0] c_dst_ra = 2'd2;

    localparam logic [1:0] c_wd_alu = 2'd0;
    localparam logic [1:0] c_wd_mem = 2'd1;
    localparam logic [1:0] c_wd_pc4 = 2'd2;

    localparam logic [1:0] c_size_word = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_byte = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Combinational instruction decoder for the multi-cycle MIPS
//               control unit.
//   i_instr      in  32 : instruction register contents
//   o_alu_sel    out 6  : ALU operation code
//   o_iclass     out 4  : instruction class for sequencing
//   o_alu_srcb   out 2  : ALU B operand select
//   o_reg_dst    out 2  : register write address select
//   o_wd_src     out 2  : register write data select
//   o_mem_size   out 2  : memory access size
//   o_illegal    out 1  : instruction is not decodable
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mips_defs::*;
(
    input  logic [31:0] i_instr,
    output logic [5:0]  o_alu_sel,
    output iclass_t     o_iclass,
    output logic [1:0]  o_alu_srcb,
    output logic [1:0]  o_reg_dst,
    output logic [1:0]  o_wd_src,
    output logic [1:0]  o_mem_size,
    output logic        o_illegal
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_instr;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    // Register and immediate fields are consumed by the datapath, not here.
    assign w_unused_instr = ^i_instr[25:6];

    always_comb begin
        o_alu_sel  = c_alu_add;
        o_iclass   = c_cls_none;
        o_alu_srcb = c_srcb_rt;
        o_reg_dst  = c_dst_rt;
        o_wd_src   = c_wd_alu;
        o_mem_size = c_size_word;
        o_illegal  = 1'b0;

        case (w_opcode)
            c_op_rtype: begin
                o_iclass  = c_cls_ralu;
                o_reg_dst = c_dst_rd;
                case (w_funct)
                    c_fn_add:  o_alu_sel = c_alu_add;
                    c_fn_sub:  o_alu_sel = c_alu_sub;
                    c_fn_and:  o_alu_sel = c_alu_and;
                    c_fn_or:   o_alu_sel = c_alu_or;
                    c_fn_sll:  o_alu_sel = c_alu_sll;
                    c_fn_jr: begin
                        o_alu_sel = c_alu_jr;
                        o_iclass  = c_cls_jr;
                    end
                    c_fn_jalr: begin
                        o_alu_sel = c_alu_jalr;
                        o_iclass  = c_cls_jalr;
                        o_wd_src  = c_wd_pc4;
                    end
                    default: begin
                        o_iclass  = c_cls_none;
                        o_reg_dst = c_dst_rt;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            c_op_ori: begin
                o_alu_sel  = c_alu_ori;
                o_iclass   = c_cls_ialu;
                o_alu_srcb = c_srcb_zext;
            end
            c_op_addi: begin
                o_alu_sel  = c_alu_addi;
                o_iclass   = c_cls_ialu;
                o_alu_srcb = c_srcb_sext;
            end
            c_op_lui: begin
                o_alu_sel  = c_alu_lui;
                o_iclass   = c_cls_ialu;
                o_alu_srcb = c_srcb_sext;
            end
            c_op_lw, c_op_lh, c_op_lb: begin
                o_iclass   = c_cls_load;
                o_alu_srcb = c_srcb_sext;
                o_wd_src   = c_wd_mem;
                if (w_opcode == c_op_lw) begin
                    o_alu_sel  = c_alu_lw;
                    o_mem_size = c_size_word;
                end else if (w_opcode == c_op_lh) begin
                    o_alu_sel  = c_alu_lh;
                    o_mem_size = c_size_half;
                end else begin
                    o_alu_sel  = c_alu_lb;
                    o_mem_size = c_size_byte;
                end
            end
            c_op_sw, c_op_sh, c_op_sb: begin
                o_iclass   = c_cls_store;
                o_alu_srcb = c_srcb_sext;
                if (w_opcode == c_op_sw) begin
                    o_alu_sel  = c_alu_sw;
                    o_mem_size = c_size_word;
                end else if (w_opcode == c_op_sh) begin
                    o_alu_sel  = c_alu_sh;
                    o_mem_size = c_size_half;
                end else begin
                    o_alu_sel  = c_alu_sb;
                    o_mem_size = c_size_byte;
                end
            end
            c_op_beq: begin
                o_alu_sel = c_alu_beq;
                o_iclass  = c_cls_branch;
            end
            c_op_bne: begin
                o_alu_sel = c_alu_bne;
                o_iclass  = c_cls_branch;
            end
            c_op_j: begin
                o_alu_sel = c_alu_j;
                o_iclass  = c_cls_j;
            end
            c_op_jal: begin
                o_alu_sel = c_alu_jal;
                o_iclass  = c_cls_jal;
                o_reg_dst = c_dst_ra;
                o_wd_src  = c_wd_pc4;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control unit. Sequences FETCH / DECODE /
//               EXEC / MEM / WB with a memory ready handshake, latches the
//               decode fields at DECODE exit and counts retired instructions.
//   clk, reset (async, active-high)
//   instr[31:0], zero, mem_ready                          : inputs
//   ALU_sel[5:0]                                          : registered ALU code
//   mem_read, mem_write, mem_size[1:0]                    : memory control
//   ir_write, pc_write, pc_src[1:0]                       : IR / PC control
//   alu_srcB[1:0], reg_write, reg_dst[1:0], wd_src[1:0]   : datapath control
//   state[2:0], illegal, retired[31:0]                    : status / debug
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [5:0]  ALU_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_srcB,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_src,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    // Live decode of the instruction register.
    logic [5:0] w_alu_sel;
    iclass_t    w_iclass;
    logic [1:0] w_alu_srcb;
    logic [1:0] w_reg_dst;
    logic [1:0] w_wd_src;
    logic [1:0] w_mem_size;
    logic       w_illegal;

    // Decode fields latched at DECODE exit.
    state_t     r_state;
    logic [5:0] r_alu_sel;
    iclass_t    r_iclass;
    logic [1:0] r_alu_srcb;
    logic [1:0] r_reg_dst;
    logic [1:0] r_wd_src;
    logic [1:0] r_mem_size;
    logic [31:0] r_retired;

    logic       w_retire;

    mc_decode u_decode (
        .i_instr    (instr),
        .o_alu_sel  (w_alu_sel),
        .o_iclass   (w_iclass),
        .o_alu_srcb (w_alu_srcb),
        .o_reg_dst  (w_reg_dst),
        .o_wd_src   (w_wd_src),
        .o_mem_size (w_mem_size),
        .o_illegal  (w_illegal)
    );

    // An instruction retires on the transition that ends it back in FETCH
    // (illegal instructions return to FETCH without retiring).
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            c_st_decode: w_retire = !w_illegal && (w_iclass == c_cls_j);
            c_st_exec:   w_retire = (r_iclass == c_cls_branch) || (r_iclass == c_cls_jr);
            c_st_mem:    w_retire = (r_iclass == c_cls_store) && mem_ready;
            c_st_wb:     w_retire = 1'b1;
            default:     w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_fetch;
            r_alu_sel  <= c_alu_add;
            r_iclass   <= c_cls_none;
            r_alu_srcb <= c_srcb_rt;
            r_reg_dst  <= c_dst_rt;
            r_wd_src   <= c_wd_alu;
            r_mem_size <= c_size_word;
            r_retired  <= 32'd0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
            case (r_state)
                c_st_fetch: begin
                    if (mem_ready) begin
                        r_state <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    r_alu_sel  <= w_alu_sel;
                    r_iclass   <= w_iclass;
                    r_alu_srcb <= w_alu_srcb;
                    r_reg_dst  <= w_reg_dst;
                    r_wd_src   <= w_wd_src;
                    r_mem_size <= w_mem_size;
                    if (w_illegal || (w_iclass == c_cls_j)) begin
                        r_state <= c_st_fetch;
                    end else if (w_iclass == c_cls_jal) begin
                        r_state <= c_st_wb;
                    end else begin
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    case (r_iclass)
                        c_cls_load, c_cls_store:  r_state <= c_st_mem;
                        c_cls_branch, c_cls_jr:   r_state <= c_st_fetch;
                        c_cls_ralu, c_cls_ialu,
                        c_cls_jalr:               r_state <= c_st_wb;
                        default:                  r_state <= c_st_fetch;
                    endcase
                end
                c_st_mem: begin
                    if (mem_ready) begin
                        r_state <= (r_iclass == c_cls_load) ? c_st_wb : c_st_fetch;
                    end
                end
                c_st_wb: begin
                    r_state <= c_st_fetch;
                end
                default: begin
                    r_state <= c_st_fetch;
                end
            endcase
        end
    end

    // Strobes are a function of state and latched fields; the FETCH/MEM
    // handshake, the DECODE-cycle jump and the branch 'zero' use live inputs.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_size  = c_size_word;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = c_pcsrc_pc4;
        reg_write = 1'b0;
        illegal   = 1'b0;
        case (r_state)
            c_st_fetch: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            c_st_decode: begin
                if (w_illegal) begin
                    illegal = 1'b1;
                end else if (w_iclass == c_cls_j) begin
                    pc_write = 1'b1;
                    pc_src   = c_pcsrc_jump;
                end
            end
            c_st_exec: begin
                if (r_iclass == c_cls_branch) begin
                    pc_write = zero;
                    pc_src   = c_pcsrc_branch;
                end else if (r_iclass == c_cls_jr) begin
                    pc_write = 1'b1;
                    pc_src   = c_pcsrc_rs;
                end
            end
            c_st_mem: begin
                mem_read  = (r_iclass == c_cls_load);
                mem_write = (r_iclass == c_cls_store);
                mem_size  = r_mem_size;
            end
            c_st_wb: begin
                reg_write = 1'b1;
                if (r_iclass == c_cls_jal) begin
                    pc_write = 1'b1;
                    pc_src   = c_pcsrc_jump;
                end else if (r_iclass == c_cls_jalr) begin
                    pc_write = 1'b1;
                    pc_src   = c_pcsrc_rs;
                end
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    assign ALU_sel  = r_alu_sel;
    assign alu_srcB = r_alu_srcb;
    assign reg_dst  = r_reg_dst;
    assign wd_src   = r_wd_src;
    assign state    = r_state;
    assign retired  = r_retired;

endmodule
`default_nettype wire
